// File: rtl/watch_alarm_if.sv
// ---------------------------------------------------------------------------
// watch_alarm_if
// Groups the switch/key inputs and the display-side outputs of the watch.
//   master : drives val, mode_btn, stop_btn, alarm_en; observes the outputs
//   slave  : the watch itself (receives the inputs, drives the outputs)
// Signals:
//   val[5:0]       value loaded in set modes
//   mode_btn       mode advance (conditioned, level-high when pressed)
//   stop_btn       alarm dismiss (conditioned, level-high when pressed)
//   alarm_en       alarm arm
//   segundos[5:0]  seconds 0..59       minutos[5:0] minutes 0..59
//   horas[4:0]     hours 0..23         alarm_h[4:0] alarm hours
//   alarm_m[5:0]   alarm minutes       mode[2:0]    current mode
//   blink          toggles every second
//   alarm          ringing indicator
// ---------------------------------------------------------------------------
interface watch_alarm_if;
   logic [5:0] val;
   logic       mode_btn;
   logic       stop_btn;
   logic       alarm_en;
   logic [5:0] segundos;
   logic [5:0] minutos;
   logic [4:0] horas;
   logic [4:0] alarm_h;
   logic [5:0] alarm_m;
   logic [2:0] mode;
   logic       blink;
   logic       alarm;

   modport master (
      output val, mode_btn, stop_btn, alarm_en,
      input  segundos, minutos, horas, alarm_h, alarm_m, mode, blink, alarm
   );

   modport slave (
      input  val, mode_btn, stop_btn, alarm_en,
      output segundos, minutos, horas, alarm_h, alarm_m, mode, blink, alarm
   );
endinterface

// File: rtl/watch_alarm.sv
// ---------------------------------------------------------------------------
// watch_alarm
// 24 h HH:MM:SS watch with one daily alarm, a ring timer and a dismiss key.
// Ports:
//   clk  system clock (CLK_HZ cycles per second)
//   rst  synchronous active-high reset
//   bus  watch_alarm_if.slave: inputs val/mode_btn/stop_btn/alarm_en,
//        registered outputs segundos/minutos/horas/alarm_h/alarm_m/mode/
//        blink/alarm (binary values, BCD is done downstream)
// ---------------------------------------------------------------------------
module watch_alarm #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int RING_SECS = 30
) (
   input  logic            clk,
   input  logic            rst,
   watch_alarm_if.slave    bus
);

   localparam int              DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
   localparam logic [5:0]      RING_INIT = 6'(RING_SECS);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_S  = 3'd3,
      SET_AH = 3'd4,
      SET_AM = 3'd5
   } mode_e;

   logic [DIV_W-1:0] div_q, div_d;
   mode_e            mode_q, mode_d;
   logic [5:0]       sec_q, sec_d;
   logic [5:0]       min_q, min_d;
   logic [4:0]       hr_q, hr_d;
   logic [4:0]       alarm_h_q, alarm_h_d;
   logic [5:0]       alarm_m_q, alarm_m_d;
   logic [5:0]       ring_q, ring_d;
   logic             blink_q, blink_d;
   logic             alarm_q, alarm_d;
   logic             mode_prev_q, mode_prev_d;
   logic             stop_prev_q, stop_prev_d;

   logic             tick_s;
   logic             mode_ev_s;
   logic             stop_ev_s;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         mode_q      <= RUN;
         sec_q       <= 6'd0;
         min_q       <= 6'd0;
         hr_q        <= 5'd0;
         alarm_h_q   <= 5'd0;
         alarm_m_q   <= 6'd0;
         ring_q      <= 6'd0;
         blink_q     <= 1'b0;
         alarm_q     <= 1'b0;
         mode_prev_q <= 1'b0;
         stop_prev_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         mode_q      <= mode_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         alarm_h_q   <= alarm_h_d;
         alarm_m_q   <= alarm_m_d;
         ring_q      <= ring_d;
         blink_q     <= blink_d;
         alarm_q     <= alarm_d;
         mode_prev_q <= mode_prev_d;
         stop_prev_q <= stop_prev_d;
      end
   end

   // Next-state logic: divider, button edges, mode sequencing, timekeeping, alarm
   always_comb begin
      tick_s      = (div_q == DIV_MAX);
      mode_ev_s   = bus.mode_btn & ~mode_prev_q;
      stop_ev_s   = bus.stop_btn & ~stop_prev_q;
      mode_prev_d = bus.mode_btn;
      stop_prev_d = bus.stop_btn;

      div_d     = tick_s ? '0 : div_q + DIV_W'(1);
      blink_d   = blink_q ^ tick_s;
      mode_d    = mode_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hr_d      = hr_q;
      alarm_h_d = alarm_h_q;
      alarm_m_d = alarm_m_q;
      ring_d    = ring_q;
      alarm_d   = alarm_q;

      // Mode sequencing; illegal codes fall back to RUN regardless of the button
      case (mode_q)
         RUN:     mode_d = mode_ev_s ? SET_H  : RUN;
         SET_H:   mode_d = mode_ev_s ? SET_M  : SET_H;
         SET_M:   mode_d = mode_ev_s ? SET_S  : SET_M;
         SET_S:   mode_d = mode_ev_s ? SET_AH : SET_S;
         SET_AH:  mode_d = mode_ev_s ? SET_AM : SET_AH;
         SET_AM:  mode_d = mode_ev_s ? RUN    : SET_AM;
         default: mode_d = RUN;
      endcase

      // Actions follow the mode in force before this edge
      case (mode_q)
         RUN: begin
            if (tick_s) begin
               if (sec_q == 6'd59) begin
                  sec_d = 6'd0;
                  if (min_q == 6'd59) begin
                     min_d = 6'd0;
                     hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
               // Trigger compares against the time being written this edge
               if (bus.alarm_en && (hr_d == alarm_h_q) && (min_d == alarm_m_q) &&
                   (sec_d == 6'd0)) begin
                  alarm_d = 1'b1;
                  ring_d  = RING_INIT;
               end else if (alarm_q) begin
                  if (ring_q <= 6'd1) begin
                     ring_d  = 6'd0;
                     alarm_d = 1'b0;
                  end else begin
                     ring_d  = ring_q - 6'd1;
                  end
               end else begin
                  ring_d = ring_q;
               end
            end else begin
               sec_d = sec_q;
            end
         end
         SET_H: begin
            if (bus.val <= 6'd23) hr_d = bus.val[4:0];
            else                  hr_d = hr_q;
         end
         SET_M: begin
            if (bus.val <= 6'd59) min_d = bus.val;
            else                  min_d = min_q;
         end
         SET_S: begin
            if (bus.val <= 6'd59) sec_d = bus.val;
            else                  sec_d = sec_q;
         end
         SET_AH: begin
            if (bus.val <= 6'd23) alarm_h_d = bus.val[4:0];
            else                  alarm_h_d = alarm_h_q;
         end
         SET_AM: begin
            if (bus.val <= 6'd59) alarm_m_d = bus.val;
            else                  alarm_m_d = alarm_m_q;
         end
         default: begin
            sec_d = sec_q;
         end
      endcase

      // Dismiss, disarm and any mode change all silence the alarm, beating a trigger
      if (stop_ev_s || !bus.alarm_en || (mode_d != mode_q)) begin
         alarm_d = 1'b0;
         ring_d  = 6'd0;
      end else begin
         alarm_d = alarm_d;
      end
   end

   assign bus.segundos = sec_q;
   assign bus.minutos  = min_q;
   assign bus.horas    = hr_q;
   assign bus.alarm_h  = alarm_h_q;
   assign bus.alarm_m  = alarm_m_q;
   assign bus.mode     = mode_q;
   assign bus.blink    = blink_q;
   assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_watch_alarm.sv
// ---------------------------------------------------------------------------
// tb_watch_alarm
// Scoreboard bench for watch_alarm (CLK_HZ=4, RING_SECS=3). The stimulus
// process steps a seconds-of-day reference model for every clock edge and
// queues the expected outputs; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_watch_alarm;

   localparam int CLK_HZ    = 4;
   localparam int RING_SECS = 3;

   typedef struct packed {
      logic [5:0] s;
      logic [5:0] m;
      logic [4:0] h;
      logic [4:0] ah;
      logic [5:0] am;
      logic [2:0] mode;
      logic       blink;
      logic       alarm;
   } obs_t;

   logic clk;
   logic rst;
   watch_alarm_if bus_if();

   watch_alarm #(.CLK_HZ(CLK_HZ), .RING_SECS(RING_SECS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: time of day kept as plain seconds since midnight
   int m_tod, m_div, m_mode, m_ring, m_ah, m_am;
   bit m_blink, m_alarm, m_pm, m_ps;

   obs_t exp_q[$];
   int   cyc_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   logic       en_r  = 1'b1;
   logic [5:0] val_r = 6'd0;

   task automatic model_step(input logic r, input logic mb, input logic sb,
                             input logic en, input logic [5:0] v);
      int  old;
      int  vi;
      bit  mev, sev, tick;
      vi = int'(v);
      if (r) begin
         m_tod = 0; m_div = 0; m_mode = 0; m_ring = 0; m_ah = 0; m_am = 0;
         m_blink = 0; m_alarm = 0; m_pm = 0; m_ps = 0;
         return;
      end
      mev  = mb && !m_pm;
      sev  = sb && !m_ps;
      m_pm = mb;
      m_ps = sb;
      tick  = (m_div == CLK_HZ - 1);
      m_div = (m_div + 1) % CLK_HZ;
      if (tick) m_blink = !m_blink;
      old = m_mode;
      if (old > 5) m_mode = 0;
      else if (mev) m_mode = (m_mode + 1) % 6;
      case (old)
         0: if (tick) begin
            m_tod = (m_tod + 1) % 86400;
            if (m_alarm) begin
               m_ring = m_ring - 1;
               if (m_ring == 0) m_alarm = 0;
            end else if (en && m_tod == m_ah * 3600 + m_am * 60) begin
               m_alarm = 1;
               m_ring  = RING_SECS;
            end
         end
         1: if (vi <= 23) m_tod = vi * 3600 + m_tod % 3600;
         2: if (vi <= 59) m_tod = (m_tod / 3600) * 3600 + vi * 60 + m_tod % 60;
         3: if (vi <= 59) m_tod = m_tod - m_tod % 60 + vi;
         4: if (vi <= 23) m_ah = vi;
         5: if (vi <= 59) m_am = vi;
         default: ;
      endcase
      if (m_mode != old || sev || !en) begin
         m_alarm = 0;
         m_ring  = 0;
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.s     = 6'(m_tod % 60);
      o.m     = 6'((m_tod / 60) % 60);
      o.h     = 5'(m_tod / 3600);
      o.ah    = 5'(m_ah);
      o.am    = 6'(m_am);
      o.mode  = 3'(m_mode);
      o.blink = m_blink;
      o.alarm = m_alarm;
      return o;
   endfunction

   // One clock edge: drive inputs, advance the model, queue the expectation
   task automatic cyc(input logic r, input logic mb, input logic sb);
      rst              = r;
      bus_if.mode_btn  = mb;
      bus_if.stop_btn  = sb;
      bus_if.alarm_en  = en_r;
      bus_if.val       = val_r;
      model_step(r, mb, sb, en_r, val_r);
      @(posedge clk);
      cycle = cycle + 1;
      exp_q.push_back(model_obs());
      cyc_q.push_back(cycle);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic to_run();
      for (int i = 0; i < 8 && m_mode != 0; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   // Walk SET_H..SET_AM loading each value, then return to RUN
   task automatic set_all(input int h, input int m, input int s, input int ah, input int am);
      int vals[5];
      vals[0] = h; vals[1] = m; vals[2] = s; vals[3] = ah; vals[4] = am;
      to_run();
      cyc(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         val_r = 6'(vals[k]);
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_until_alarm();
      int i;
      for (i = 0; i < 400 && !m_alarm; i++) cyc(1'b0, 1'b0, 1'b0);
      n_checks = n_checks + 1;
      if (!m_alarm) begin
         n_fail = n_fail + 1;
         $display("FAIL alarm_wait: alarm not reached after %0d cycles, required within 400", i);
      end
   endtask

   // Monitor: compares every registered output snapshot against the queue
   initial begin
      obs_t e, a;
      int   c;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            a.s = bus_if.segundos; a.m = bus_if.minutos; a.h = bus_if.horas;
            a.ah = bus_if.alarm_h; a.am = bus_if.alarm_m; a.mode = bus_if.mode;
            a.blink = bus_if.blink; a.alarm = bus_if.alarm;
            n_checks = n_checks + 1;
            if (a !== e) begin
               n_fail = n_fail + 1;
               $display("FAIL outputs@cycle%0d: got %0d:%0d:%0d al=%0d:%0d mode=%0d blink=%0b alarm=%0b, expected %0d:%0d:%0d al=%0d:%0d mode=%0d blink=%0b alarm=%0b",
                        c, a.h, a.m, a.s, a.ah, a.am, a.mode, a.blink, a.alarm,
                        e.h, e.m, e.s, e.ah, e.am, e.mode, e.blink, e.alarm);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, m;
      rst = 1'b1; bus_if.mode_btn = 1'b0; bus_if.stop_btn = 1'b0;
      bus_if.alarm_en = 1'b1; bus_if.val = 6'd0;

      // Reset, first tick after CLK_HZ edges, reset mid-count
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      idle(6);
      cyc(1'b1, 1'b0, 1'b0);
      idle(2);

      // Midnight rollover
      set_all(23, 59, 58, 0, 0);
      idle(10);

      // Out-of-range loads and a held mode button
      set_all(5, 10, 20, 1, 2);
      cyc(1'b0, 1'b1, 1'b0);
      val_r = 6'd24; idle(2);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      val_r = 6'd40; idle(2);
      val_r = 6'd63; idle(2);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
      idle(2);
      to_run();

      // Full ring, then dismissed ring, then disarmed trigger
      en_r = 1'b1;
      set_all(7, 29, 59, 7, 30);
      run_until_alarm();
      idle(CLK_HZ * (RING_SECS + 2));
      set_all(7, 29, 59, 7, 30);
      run_until_alarm();
      idle(CLK_HZ);
      cyc(1'b0, 1'b0, 1'b1);
      idle(CLK_HZ * 4);
      set_all(7, 29, 59, 7, 30);
      en_r = 1'b0;
      idle(CLK_HZ * 3);
      en_r = 1'b1;
      idle(CLK_HZ * 2);

      // Loading the alarm time directly does not ring; mode press while ringing
      set_all(7, 30, 0, 7, 30);
      idle(CLK_HZ * 3);
      set_all(7, 29, 59, 7, 30);
      run_until_alarm();
      idle(2);
      cyc(1'b0, 1'b1, 1'b0);
      idle(3);
      to_run();

      // Randomised alarm scenarios around a trigger
      for (int t = 0; t < 8; t++) begin
         h = $urandom_range(0, 23);
         m = $urandom_range(0, 58);
         set_all(h, m, $urandom_range(56, 59), h, m + 1);
         for (int i = 0; i < 60; i++) begin
            en_r = ($urandom_range(0, 19) != 0);
            cyc(1'b0, 1'b0, ($urandom_range(0, 29) == 0));
         end
         en_r = 1'b1;
      end

      // Fully random inputs
      for (int i = 0; i < 2500; i++) begin
         val_r = 6'($urandom_range(0, 63));
         en_r  = ($urandom_range(0, 9) != 0);
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 15) == 0));
      end
      idle(2);

      @(negedge clk);
      @(negedge clk);
      n_checks = n_checks + 1;
      if (exp_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/watch_alarm.md
Name: watch_alarm

Overview:
- Parametrised successor to the board's 24 h watch: HH:MM:SS timekeeping from a divided system clock, with one programmable daily alarm.
- Adds synchronous reset, a configurable clock rate, an alarm register pair, an alarm ring timer and a dismiss button.
- Sits between the switch/key inputs and the 7-segment decode logic.
- Outputs are binary values; BCD conversion happens downstream.

Parameters:
- CLK_HZ, 50_000_000, system clock cycles per second; must be ≥2.
- RING_SECS, 30, seconds the alarm output stays asserted if not dismissed; 1..63.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- val  in  6  value to load in set modes (SW[5:0])
- mode_btn  in  1  mode advance; already synchronised and debounced, level-high when pressed
- stop_btn  in  1  alarm dismiss; same conditioning as mode_btn
- alarm_en  in  1  alarm arm; 0 blocks triggering and clears a ringing alarm
- segundos  out  6  current seconds, 0..59
- minutos  out  6  current minutes, 0..59
- horas  out  5  current hours, 0..23
- alarm_h  out  5  alarm hours, 0..23
- alarm_m  out  6  alarm minutes, 0..59
- mode  out  3  current mode encoding, see Behaviour
- blink  out  1  toggles once per second
- alarm  out  1  ringing indicator

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, mode=RUN, divider=0, ring counter=0, button history regs=0. Reset overrides every other event, including during ringing or in a set mode.
- Divider: counter runs 0..CLK_HZ-1, width $clog2(CLK_HZ). On the edge where counter==CLK_HZ-1: counter<=0, blink toggles, tick is active for that edge only. The divider runs in all modes.
- First tick occurs at the CLK_HZ-th edge after rst is released.
- Button edges: each button has a previous-value register. A press event is prev==0 and current==1. Holding a button produces exactly one event.
- Mode encoding: RUN=0, SET_H=1, SET_M=2, SET_S=3, SET_AH=4, SET_AM=5.
  - A mode_btn event advances the mode: 0→1→2→3→4→5→0. Codes 6 and 7 are unreachable; if reached, the next edge forces RUN.
- Set modes: every edge loads val into the selected register only if in range (hours ≤23, min/sec ≤59). An out-of-range val leaves the register unchanged.
  - SET_AH loads alarm_h; SET_AM loads alarm_m.
  - Time does not advance in any set mode; ticks are discarded.
  - A mode change clears alarm and the ring counter.
- RUN, on tick:
  - Seconds increment; 59 wraps to 0 and carries to minutes.
  - Minutes 59 wrap to 0 and carry to hours; hours 23 wrap to 0.
  - 23:59:59 → 00:00:00 in one tick.
- Alarm trigger: in RUN, on the tick edge where the new time equals alarm_h:alarm_m:00 and alarm_en=1, alarm<=1 and ring counter<=RING_SECS.
  - Loading the matching time in a set mode does not trigger.
- Ringing:
  - Each subsequent tick in RUN decrements the ring counter.
  - On the tick where the counter reaches 0, alarm<=0.
  - The alarm is therefore high for exactly RING_SECS ticks.
- Dismiss: a stop_btn event, or alarm_en=0, clears alarm and the ring counter on that edge.
- Simultaneous events:
  - Dismiss (or alarm_en=0) on the same edge as a trigger: alarm stays 0.
  - A trigger while already ringing cannot occur (daily match only).
  - mode_btn event and tick on the same edge: the mode changes and the tick is applied under the old mode.
- Latency: all outputs are registered; changes are visible the cycle after the causing edge. No combinational path from inputs to outputs.

Test Plan (CLK_HZ=4, RING_SECS=3):
- Reset then run 4 cycles → segundos=1 and blink=1 at cycle 4. Assert rst mid-count → all outputs 0 on the next edge.
- Set 23:59:58 via SET_H val=23, SET_M val=59, SET_S val=58, return to RUN → after 2 ticks horas=0, minutos=0, segundos=0.
- In SET_H drive val=24, then val=40 in SET_M → horas and minutos hold their previous values. Hold mode_btn high for 10 cycles → mode advances by exactly 1.
- alarm_h=7, alarm_m=30, alarm_en=1, time 07:29:59 → alarm rises on the tick to 07:30:00 and falls exactly 3 ticks later.
- Same setup with a stop_btn event 1 tick after trigger → alarm=0 on the next edge. Repeat with alarm_en=0 at the trigger tick → alarm never rises.
- Load 07:30:00 via SET_S while alarm=07:30 → no ring. Press mode_btn while ringing → alarm clears and mode=SET_H.
